rhs_cmd_sequencer: RTL and testbench

Command sequencer for the dual-lane RHS2116 SPI master. It replays a host-loaded initialisation list, then issues CONVERT commands over all channels on every sample tick. It compensates the RHS2116 two-command result pipeline and delivers channel-tagged samples for both lanes. It sits between the host/register interface and the SPI master's `data_in_v`/`ready_out`/`data_out_v` handshake.

---
 rtl/rhs_seq_pkg.sv | 24 ++
 rtl/rhs_cmd_ram.sv | 22 ++
 rtl/rhs_cmd_sequencer.sv | 178 +++++++++++++++++
 tb/tb_rhs_cmd_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rhs_seq_pkg.sv
// rtl/rhs_seq_pkg.sv - shared types and command encoding for the RHS2116 command sequencer
package rhs_seq_pkg;

  localparam int CH_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_ISSUE,
    ST_INIT_WAIT,
    ST_RUN_TICK,
    ST_RUN_ISSUE,
    ST_RUN_WAIT
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
  } tag_t;

  function automatic logic [31:0] convert_cmd(input logic [CH_W-1:0] ch);
    return {10'b0, ch, 16'h0000};
  endfunction

endpackage

// File: rtl/rhs_cmd_ram.sv
// rtl/rhs_cmd_ram.sv - init-list RAM, synchronous write and registered read
module rhs_cmd_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/rhs_cmd_sequencer.sv
// rtl/rhs_cmd_sequencer.sv - replays the init list, then converts all channels per sample tick
module rhs_cmd_sequencer
  import rhs_seq_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_CH      = 16,
  parameter int INIT_DEPTH  = 32,
  localparam int AW = $clog2(INIT_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   sample_tick,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [WORD_LENGTH-1:0] cfg_data,
  input  logic [AW:0]            init_len,
  input  logic                   spi_ready,
  input  logic                   spi_done,
  input  logic [WORD_LENGTH-1:0] spi_rx_1,
  input  logic [WORD_LENGTH-1:0] spi_rx_2,
  output logic                   spi_tx_v,
  output logic [WORD_LENGTH-1:0] spi_tx,
  output logic                   result_v,
  output logic [5:0]             result_ch,
  output logic [15:0]            result_1,
  output logic [15:0]            result_2,
  output logic                   busy,
  output logic                   overrun
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t                 state, state_n;
  logic [AW:0]            ptr, ptr_n, len, len_n;
  logic [CH_W-1:0]        ch, ch_n;
  tag_t [1:0]             tags, tags_n;
  logic                   stop_pend, stop_pend_n, overrun_n, to_idle;
  logic                   tx_v_n, res_v_n;
  logic [WORD_LENGTH-1:0] tx_n, rd_data;
  logic [5:0]             res_ch_n;
  logic [15:0]            res1_n, res2_n;
  logic                   unused_rx;

  assign unused_rx = ^{spi_rx_1[WORD_LENGTH-1:16], spi_rx_2[WORD_LENGTH-1:16]};

  // Read address follows the next pointer so the word is ready on entry to INIT_ISSUE.
  rhs_cmd_ram #(.WIDTH(WORD_LENGTH), .DEPTH(INIT_DEPTH)) u_ram (
    .clk   (clk),
    .we    (cfg_we && (state == ST_IDLE)),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (ptr_n[AW-1:0]),
    .rdata (rd_data)
  );

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    len_n       = len;
    ch_n        = ch;
    tags_n      = tags;
    stop_pend_n = stop_pend | stop;
    overrun_n   = overrun;
    to_idle     = 1'b0;
    tx_v_n      = 1'b0;
    tx_n        = spi_tx;
    res_v_n     = 1'b0;
    res_ch_n    = result_ch;
    res1_n      = result_1;
    res2_n      = result_2;
    case (state)
      ST_IDLE: begin
        stop_pend_n = 1'b0;
        if (start) begin
          overrun_n = 1'b0;
          tags_n    = '0;
          ptr_n     = '0;
          len_n     = init_len;
          state_n   = (init_len == '0) ? ST_RUN_TICK : ST_INIT_ISSUE;
        end
      end
      ST_INIT_ISSUE: begin
        if (stop_pend_n) to_idle = 1'b1;
        else if (spi_ready) begin
          tx_v_n  = 1'b1;
          tx_n    = rd_data;
          state_n = ST_INIT_WAIT;
        end
      end
      ST_INIT_WAIT: begin
        if (spi_done) begin
          if (stop_pend_n) to_idle = 1'b1;
          else begin
            ptr_n   = ptr + (AW+1)'(1);
            state_n = (ptr_n == len) ? ST_RUN_TICK : ST_INIT_ISSUE;
          end
        end
      end
      ST_RUN_TICK: begin
        if (stop_pend_n) to_idle = 1'b1;
        else if (sample_tick) begin
          ch_n    = '0;
          state_n = ST_RUN_ISSUE;
        end
      end
      ST_RUN_ISSUE: begin
        if (stop_pend_n) to_idle = 1'b1;
        else if (spi_ready) begin
          tx_v_n  = 1'b1;
          tx_n    = WORD_LENGTH'(convert_cmd(ch));
          state_n = ST_RUN_WAIT;
        end
      end
      ST_RUN_WAIT: begin
        if (spi_done) begin
          // The RX words of this transfer belong to the command issued two transfers ago.
          if (tags[1].valid) begin
            res_v_n  = 1'b1;
            res_ch_n = tags[1].ch;
            res1_n   = spi_rx_1[15:0];
            res2_n   = spi_rx_2[15:0];
          end
          tags_n = {tags[0], tag_t'{valid: 1'b1, ch: ch}};
          if (stop_pend_n) to_idle = 1'b1;
          else if (ch == LAST_CH) state_n = ST_RUN_TICK;
          else begin
            ch_n    = ch + CH_W'(1);
            state_n = ST_RUN_ISSUE;
          end
        end
      end
      default: to_idle = 1'b1;
    endcase
    if (sample_tick && ((state == ST_RUN_ISSUE) || (state == ST_RUN_WAIT))) overrun_n = 1'b1;
    if (to_idle) begin
      state_n     = ST_IDLE;
      tags_n      = '0;
      stop_pend_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      len       <= '0;
      ch        <= '0;
      tags      <= '0;
      stop_pend <= 1'b0;
      overrun   <= 1'b0;
      spi_tx_v  <= 1'b0;
      spi_tx    <= '0;
      result_v  <= 1'b0;
      result_ch <= '0;
      result_1  <= '0;
      result_2  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      len       <= len_n;
      ch        <= ch_n;
      tags      <= tags_n;
      stop_pend <= stop_pend_n;
      overrun   <= overrun_n;
      spi_tx_v  <= tx_v_n;
      spi_tx    <= tx_n;
      result_v  <= res_v_n;
      result_ch <= res_ch_n;
      result_1  <= res1_n;
      result_2  <= res2_n;
      busy      <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_rhs_cmd_sequencer.sv
// tb/tb_rhs_cmd_sequencer.sv - scoreboard bench for rhs_cmd_sequencer with a behavioural SPI master
module tb_rhs_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, sample_tick, cfg_we;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic [5:0]  init_len;
  logic        spi_ready, spi_done;
  logic [31:0] spi_rx_1, spi_rx_2;
  logic        spi_tx_v;
  logic [31:0] spi_tx;
  logic        result_v;
  logic [5:0]  result_ch;
  logic [15:0] result_1, result_2;
  logic        busy, overrun;

  always #5 clk = ~clk;

  rhs_cmd_sequencer #(.WORD_LENGTH(32), .NUM_CH(4), .INIT_DEPTH(32)) dut (
    .clk(clk), .reset(rst), .start(start), .stop(stop), .sample_tick(sample_tick),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .init_len(init_len),
    .spi_ready(spi_ready), .spi_done(spi_done), .spi_rx_1(spi_rx_1), .spi_rx_2(spi_rx_2),
    .spi_tx_v(spi_tx_v), .spi_tx(spi_tx), .result_v(result_v), .result_ch(result_ch),
    .result_1(result_1), .result_2(result_2), .busy(busy), .overrun(overrun)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int n_results = 0;
  logic [31:0] tx_log[$];
  logic [5:0]  hist[$];
  logic [5:0]  res_ch_log[$];
  logic [37:0] exp_q[$];
  int          xfer_idx, n_init, cnt;
  logic [31:0] cur_word, r1, r2;
  logic [31:0] init_words [3] = '{32'hA0FF0000, 32'h80200001, 32'hE8000000};

  // SPI master plus RHS2116 model: a CONVERT's result returns two transfers later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_ready <= 1'b1;
      spi_done  <= 1'b0;
      spi_rx_1  <= '0;
      spi_rx_2  <= '0;
      cnt       <= 0;
    end else begin
      spi_done <= 1'b0;
      if (spi_tx_v) begin
        tx_log.push_back(spi_tx);
        cur_word  <= spi_tx;
        spi_ready <= 1'b0;
        cnt       <= 3;
      end else if (cnt > 1) begin
        cnt <= cnt - 1;
      end else if (cnt == 1) begin
        cnt = 0;
        r1 = $urandom;
        r2 = $urandom;
        spi_rx_1  <= r1;
        spi_rx_2  <= r2;
        spi_done  <= 1'b1;
        spi_ready <= 1'b1;
        if (xfer_idx >= n_init) begin
          hist.push_back(cur_word[21:16]);
          if (hist.size() >= 3) exp_q.push_back({hist[hist.size()-3], r1[15:0], r2[15:0]});
        end
        xfer_idx++;
      end
    end
  end

  always @(negedge clk) begin
    if (result_v === 1'b1) begin
      logic [37:0] e;
      n_results++;
      res_ch_log.push_back(result_ch);
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_result got ch=%0d r1=%h r2=%h want none", result_ch, result_1, result_2);
      end else begin
        e = exp_q.pop_front();
        if ({result_ch, result_1, result_2} !== e)
          $display("FAIL result got %h want %h", {result_ch, result_1, result_2}, e);
        else pass_cnt++;
      end
    end
  end

  task automatic wait_tx(input int n);
    for (int i = 0; i < 300 && tx_log.size() < n; i++) @(negedge clk);
  endtask

  task automatic do_start(input int len);
    @(negedge clk);
    init_len = 6'(len);
    tx_log.delete();
    hist.delete();
    xfer_idx = 0;
    n_init = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_stop;
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic tick;
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
  endtask

  task automatic check_tx_words;
    logic [31:0] got;
    total_cnt++;
    if (tx_log.size() != 3) $display("FAIL init_tx_count got %0d want 3", tx_log.size());
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 32'hxxxxxxxx;
      total_cnt++;
      if (got !== init_words[i]) $display("FAIL init_word%0d got %h want %h", i, got, init_words[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset;
    total_cnt++;
    if ({spi_tx_v, spi_tx, result_v, result_ch, result_1, result_2, busy, overrun} !== '0)
      $display("FAIL reset_outputs got %h want 0",
               {spi_tx_v, spi_tx, result_v, result_ch, result_1, result_2, busy, overrun});
    else pass_cnt++;
  endtask

  task automatic test_init;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 5'(i); cfg_data = init_words[i];
    end
    @(negedge clk) cfg_we = 1'b0;
    init_len = 6'd3; tx_log.delete(); hist.delete(); xfer_idx = 0; n_init = 3;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    total_cnt++;
    if (spi_tx_v !== 1'b0) $display("FAIL start_latency_c1 got %b want 0", spi_tx_v); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (spi_tx_v !== 1'b1) $display("FAIL start_latency_c2 got %b want 1", spi_tx_v); else pass_cnt++;
    wait_tx(3);
    repeat (10) @(negedge clk);
    check_tx_words();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL init_busy got %b want 1", busy); else pass_cnt++;
    do_stop();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL init_stop_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_convert;
    int r0;
    logic [5:0] want_ch [6] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd0, 6'd1};
    logic [31:0] want;
    r0 = n_results;
    res_ch_log.delete();
    do_start(0);
    repeat (2) @(negedge clk);
    tick();
    wait_tx(4);
    repeat (10) @(negedge clk);
    tick();
    wait_tx(8);
    repeat (10) @(negedge clk);
    total_cnt++;
    if (tx_log.size() != 8) $display("FAIL conv_tx_count got %0d want 8", tx_log.size()); else pass_cnt++;
    for (int i = 0; i < 8 && i < tx_log.size(); i++) begin
      want = {10'b0, 6'(i % 4), 16'h0000};
      total_cnt++;
      if (tx_log[i] !== want) $display("FAIL conv_tx%0d got %h want %h", i, tx_log[i], want); else pass_cnt++;
    end
    total_cnt++;
    if (n_results - r0 != 6) $display("FAIL conv_result_count got %0d want 6", n_results - r0); else pass_cnt++;
    for (int i = 0; i < 6 && i < res_ch_log.size(); i++) begin
      total_cnt++;
      if (res_ch_log[i] !== want_ch[i]) $display("FAIL conv_ch%0d got %0d want %0d", i, res_ch_log[i], want_ch[i]);
      else pass_cnt++;
    end
    do_stop();
  endtask

  task automatic test_overrun;
    do_start(0);
    tick();
    wait_tx(2);
    tick();
    total_cnt++;
    if (overrun !== 1'b1) $display("FAIL overrun_set got %b want 1", overrun); else pass_cnt++;
    repeat (20) @(negedge clk);
    total_cnt++;
    if (tx_log.size() != 4) $display("FAIL overrun_tx_count got %0d want 4", tx_log.size()); else pass_cnt++;
    total_cnt++;
    if (overrun !== 1'b1) $display("FAIL overrun_sticky got %b want 1", overrun); else pass_cnt++;
    do_stop();
    do_start(0);
    total_cnt++;
    if (overrun !== 1'b0) $display("FAIL overrun_clear got %b want 0", overrun); else pass_cnt++;
    do_stop();
  endtask

  task automatic test_stop_wait;
    bit idle_seen;
    do_start(0);
    tick();
    wait_tx(2);
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    for (int i = 0; i < 20 && spi_done !== 1'b1; i++) @(negedge clk);
    total_cnt++;
    if (spi_done !== 1'b1) $display("FAIL stop_done_seen got %b want 1", spi_done); else pass_cnt++;
    idle_seen = 1'b0;
    for (int k = 0; k < 2 && !idle_seen; k++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) idle_seen = 1'b1;
    end
    total_cnt++;
    if (!idle_seen) $display("FAIL stop_idle got busy=%b want 0 within 2 cycles", busy); else pass_cnt++;
    repeat (10) @(negedge clk);
    total_cnt++;
    if (tx_log.size() != 2) $display("FAIL stop_no_more_tx got %0d want 2", tx_log.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid_init;
    do_start(3);
    wait_tx(1);
    @(negedge clk) rst = 1'b1;
    #1;
    total_cnt++;
    if ({spi_tx_v, spi_tx, result_v, result_ch, result_1, result_2, busy, overrun} !== '0)
      $display("FAIL midreset_outputs got %h want 0",
               {spi_tx_v, spi_tx, result_v, result_ch, result_1, result_2, busy, overrun});
    else pass_cnt++;
    @(negedge clk) rst = 1'b0;
    do_start(3);
    wait_tx(3);
    repeat (10) @(negedge clk);
    check_tx_words();
  endtask

  task automatic test_cfg_busy;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL cfg_busy_state got %b want 1", busy); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 5'(i); cfg_data = 32'hDEAD_BEE0 + 32'(i);
    end
    @(negedge clk) cfg_we = 1'b0;
    do_stop();
    do_start(3);
    wait_tx(3);
    repeat (10) @(negedge clk);
    check_tx_words();
    do_stop();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; sample_tick = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_data = '0; init_len = '0; xfer_idx = 0; n_init = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_init();
    test_convert();
    test_overrun();
    test_stop_wait();
    test_reset_mid_init();
    test_cfg_busy();
    repeat (5) @(negedge clk);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL missing_results got %0d pending want 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
